// File: rtl/inst_pkg.sv
// Shared RV32I encoding constants: instruction formats, major opcodes, canonical NOP.
// No timing; types and constants only.
// No handshake; also consumed by the core's immediate decoder.
package inst_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // opcode[6:2]; opcode[1:0] is always 2'b11 for the 32-bit encoding space
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_HOLD = 2'd2
    } enc_state_e;

    function automatic logic fmt_legal(input logic [2:0] fmt);
        return fmt <= 3'd5;
    endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational RV32I field packer; optional immediate range check under INST_ENC_RANGE_CHECK_EN.
// Latency: zero cycles (pure combinational).
// No handshake; caller registers inst/err.
module imm_pack
    import inst_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [4:0]  opc,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    logic [6:0] opcode;
    logic       align_err;
    logic       range_err;

    assign opcode = {opc, 2'b11};

    always_comb begin
        inst      = NOP_INST;
        align_err = 1'b0;
        case (fmt)
            FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: inst = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: begin
                inst      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                align_err = imm[0];
            end
            FMT_U: inst = {imm[31:12], rd, opcode};
            FMT_J: begin
                inst      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                align_err = imm[0];
            end
            default: inst = NOP_INST;
        endcase
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = imm;

    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = (simm < -32'sd2048)    || (simm > 32'sd2047);
            FMT_B:        range_err = (simm < -32'sd4096)    || (simm > 32'sd4094);
            FMT_J:        range_err = (simm < -32'sd1048576) || (simm > 32'sd1048574);
            FMT_U:        range_err = (imm[11:0] != 12'h000);
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign err = !fmt_legal(fmt) || align_err || range_err;

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: decoded fields in, packed word plus sequential address out (INST_ENC_RANGE_CHECK_EN widens out_err).
// Latency: accept at cycle N -> out_valid at N+2; one word per 3 cycles at best.
// Backpressure: in_ready low while a word is packed or held; outputs frozen until out_ready.
module inst_encoder
    import inst_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [4:0]        in_opc,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    enc_state_e        state_q, state_d;
    logic [2:0]        fmt_q, fmt_d;
    logic [4:0]        opc_q, opc_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [6:0]        funct7_q, funct7_d;
    logic [31:0]       imm_q, imm_d;
    logic [31:0]       inst_q, inst_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [31:0]       pack_inst;
    logic              pack_err;

    imm_pack u_imm_pack (
        .fmt    (fmt_q),
        .opc    (opc_q),
        .rd     (rd_q),
        .rs1    (rs1_q),
        .rs2    (rs2_q),
        .funct3 (funct3_q),
        .funct7 (funct7_q),
        .imm    (imm_q),
        .inst   (pack_inst),
        .err    (pack_err)
    );

    always_comb begin
        state_d  = state_q;
        fmt_d    = fmt_q;
        opc_d    = opc_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        funct3_d = funct3_q;
        funct7_d = funct7_q;
        imm_d    = imm_q;
        inst_d   = inst_q;
        err_d    = err_q;
        addr_d   = addr_q;

        // flush wins over both handshakes; the in-flight word is simply abandoned
        if (flush) begin
            state_d = ST_IDLE;
            addr_d  = BASE_ADDR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        fmt_d    = in_fmt;
                        opc_d    = in_opc;
                        rd_d     = in_rd;
                        rs1_d    = in_rs1;
                        rs2_d    = in_rs2;
                        funct3_d = in_funct3;
                        funct7_d = in_funct7;
                        imm_d    = in_imm;
                        state_d  = ST_PACK;
                    end
                end
                ST_PACK: begin
                    inst_d  = pack_inst;
                    err_d   = pack_err;
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        addr_d  = addr_q + ADDR_W'(4);
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            fmt_q    <= '0;
            opc_q    <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            imm_q    <= '0;
            inst_q   <= '0;
            err_q    <= 1'b0;
            addr_q   <= BASE_ADDR;
        end else begin
            state_q  <= state_d;
            fmt_q    <= fmt_d;
            opc_q    <= opc_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            imm_q    <= imm_d;
            inst_q   <= inst_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
        end
    end

    // in_ready drops during flush so a same-cycle bundle is never seen as accepted
    assign in_ready  = (state_q == ST_IDLE) && !flush;
    assign out_valid = (state_q == ST_HOLD);
    assign out_inst  = inst_q;
    assign out_err   = err_q;
    assign out_addr  = addr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder with hand-packed expected words.
module tb_inst_encoder;
    import inst_pkg::*;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_1000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_fmt = '0;
    logic [4:0]        in_opc = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [2:0]        in_funct3 = '0;
    logic [6:0]        in_funct7 = '0;
    logic [31:0]       in_imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    int          n_checks = 0;
    int          n_errors = 0;
    string       cur = "reset";
    logic [31:0] exp_addr;
    logic [31:0] range_exp_err;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opc    (in_opc),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h", cur, tag, got, exp);
        end
    endtask

    // Presents one bundle, returns at the negedge of the PACK cycle.
    task automatic send(input logic [2:0] fmt, input logic [4:0] opc, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        @(negedge clk);
        in_fmt = fmt; in_opc = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        check("in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("pack_valid", out_valid, 0);
    endtask

    task automatic expect_word(input logic [31:0] inst, input logic err);
        @(negedge clk);
        check("valid", out_valid, 1);
        check("inst", out_inst, inst);
        check("err", out_err, err);
        check("addr", out_addr, exp_addr);
        check("in_ready_hold", in_ready, 0);
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        exp_addr = exp_addr + 32'd4;
        @(negedge clk);
        check("idle_valid", out_valid, 0);
        check("next_addr", out_addr, exp_addr);
    endtask

    initial begin
        exp_addr = BASE;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_inst", out_inst, 0);
        check("rst_err", out_err, 0);
        check("rst_addr", out_addr, BASE);

        cur = "addi";
        send(3'd1, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_word(32'h0050_0093, 1'b0);
        release_word();

        cur = "flush_idle";
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        exp_addr = BASE;
        @(negedge clk);
        check("addr", out_addr, BASE);

        cur = "sw";
        send(3'd2, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        expect_word(32'h0020_A423, 1'b0);
        release_word();

        cur = "jal";
        send(3'd5, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        expect_word(32'h0080_00EF, 1'b0);
        release_word();

        cur = "add";
        send(3'd0, OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEAD_BEEF);
        expect_word(32'h0020_81B3, 1'b0);
        release_word();

        cur = "sub";
        send(3'd0, OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
        expect_word(32'h4020_81B3, 1'b0);
        release_word();

        cur = "beq_m4";
        send(3'd3, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        expect_word(32'hFE00_0EE3, 1'b0);
        release_word();

        cur = "beq_m3";
        send(3'd3, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFD);
        expect_word(32'hFE00_0EE3, 1'b1);
        release_word();

        cur = "jal_odd";
        send(3'd5, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        expect_word(32'h0080_00EF, 1'b1);
        release_word();

        cur = "lui_stall";
        send(3'd4, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        expect_word(32'h1234_52B7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_inst", out_inst, 32'h1234_52B7);
            check("stall_err", out_err, 0);
            check("stall_addr", out_addr, exp_addr);
            check("stall_in_ready", in_ready, 0);
        end
        release_word();

        cur = "illegal_fmt";
        send(3'd7, OPC_OP, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFF_FFFF);
        expect_word(NOP_INST, 1'b1);
        // flush collides with an output handshake: the word must be dropped
        out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        out_ready = 1'b0;
        exp_addr = BASE;
        @(negedge clk);
        check("flush_valid", out_valid, 0);
        check("flush_addr", out_addr, BASE);

        cur = "addi_2048";
`ifdef INST_ENC_RANGE_CHECK_EN
        range_exp_err = 32'd1;
`else
        range_exp_err = 32'd0;
`endif
        send(3'd1, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        expect_word(32'h8000_0093, range_exp_err[0]);
        release_word();

        cur = "reset_hold";
        send(3'd1, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        expect_word(32'h0010_0093, 1'b0);
        rst_n = 1'b0;
        #1;
        check("valid", out_valid, 0);
        check("addr", out_addr, BASE);
        check("inst", out_inst, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready", in_ready, 1);
        check("valid_after", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
